// File: rtl/map_ram_arbiter_if.sv
// Signal bundle between the two map requesters, the arbiter and the map BRAM.
// The master side is the requesters plus the BRAM; the slave side is the arbiter.
interface map_ram_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              wr0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              lock0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] bram_map_addr;
    logic              bram_map_wr;
    logic [DATA_W-1:0] bram_map_dwrite;
    logic [DATA_W-1:0] bram_map_data;

    logic              busy;

    // Handshake: reqN rises with its fields stable and stays high until ackN;
    // ackN is a one-cycle pulse and reqN drops on the edge that ends that pulse.
    modport master (
        output req0, wr0, addr0, wdata0, lock0, req1, addr1, bram_map_data,
        input  ack0, rdata0, ack1, rdata1, bram_map_addr, bram_map_wr,
               bram_map_dwrite, busy
    );

    modport slave (
        input  req0, wr0, addr0, wdata0, lock0, req1, addr1, bram_map_data,
        output ack0, rdata0, ack1, rdata1, bram_map_addr, bram_map_wr,
               bram_map_dwrite, busy
    );
endinterface

// File: rtl/map_ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port map BRAM with one
// cycle of read latency; port 0 may lock the BRAM for read-modify-write.
module map_ram_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    map_ram_arbiter_if.slave        bus,
    output logic [1:0]              dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              last_grant;
    logic              lock_held;
    logic              owner;
    logic              owner_wr;
    logic              elig1;
    logic              grant_any;
    logic              grant_sel;

    logic              ack0_q;
    logic              ack1_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dwrite_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // A held lock makes port 1 invisible, so the tie rule never applies then.
    always_comb begin
        elig1     = bus.req1 && !lock_held;
        grant_any = bus.req0 || elig1;
        grant_sel = 1'b0;
        if (bus.req0 && elig1) begin
            grant_sel = ~last_grant;
        end else if (elig1) begin
            grant_sel = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = ISSUE;
            ISSUE:   state_next = owner_wr ? RESP : WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            lock_held  <= 1'b0;
            owner      <= 1'b0;
            owner_wr   <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            dwrite_q   <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        owner_wr   <= !grant_sel && bus.wr0;
                        wr_q       <= !grant_sel && bus.wr0;
                        addr_q     <= grant_sel ? bus.addr1 : bus.addr0;
                        if (!grant_sel) begin
                            dwrite_q <= bus.wdata0;
                        end
                    end
                end
                ISSUE: begin
                    wr_q <= 1'b0;
                    // Only port 0 can own a write, so completion is port 0's.
                    if (owner_wr) begin
                        ack0_q    <= 1'b1;
                        lock_held <= bus.lock0;
                    end
                end
                WAIT: begin
                    if (owner) begin
                        rdata1_q <= bus.bram_map_data;
                        ack1_q   <= 1'b1;
                    end else begin
                        rdata0_q  <= bus.bram_map_data;
                        ack0_q    <= 1'b1;
                        lock_held <= bus.lock0;
                    end
                end
                RESP: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ack0            = ack0_q;
    assign bus.ack1            = ack1_q;
    assign bus.rdata0          = rdata0_q;
    assign bus.rdata1          = rdata1_q;
    assign bus.bram_map_addr   = addr_q;
    assign bus.bram_map_wr     = wr_q;
    assign bus.bram_map_dwrite = dwrite_q;
    assign bus.busy            = (state != IDLE) || lock_held;
    assign dbg_state           = state;
endmodule

// File: tb/tb_map_ram_arbiter.sv
// Bench for map_ram_arbiter: directed scenarios plus random two-port traffic,
// with per-port expected-data queues drained by an independent monitor.
module tb_map_ram_arbiter;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;
    localparam int BUDGET = 500;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    map_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    map_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp0_q[$];
    logic [15:0] exp1_q[$];
    logic [63:0] wexp_q[$];
    int          ack_log[$];

    logic [15:0] ref_mem  [logic [18:0]];
    logic [15:0] bram_mem [logic [18:0]];
    logic [15:0] last_rd0;
    logic [15:0] bram_rd_word;

    function automatic logic [15:0] init_word(input logic [18:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_word(input logic [18:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // ---------------- BRAM model: read-first, one cycle read latency
    always @(posedge clk) begin
        bram_rd_word = bram_mem.exists(bus.bram_map_addr) ? bram_mem[bus.bram_map_addr]
                                                          : init_word(bus.bram_map_addr);
        if (bus.bram_map_wr) bram_mem[bus.bram_map_addr] = bus.bram_map_dwrite;
        bus.bram_map_data <= bram_rd_word;
    end

    // ---------------- monitor / scoreboard
    always @(negedge clk) begin
        if (bus.ack0 || bus.ack1) check("ack_onehot", 64'(bus.ack0 & bus.ack1), 64'd0);
        if (bus.ack0) begin
            ack_log.push_back(0);
            if (exp0_q.size() == 0) note_fail("ack0_unexpected");
            else check("rdata0", 64'(bus.rdata0), 64'(exp0_q.pop_front()));
        end
        if (bus.ack1) begin
            ack_log.push_back(1);
            if (exp1_q.size() == 0) note_fail("ack1_unexpected");
            else check("rdata1", 64'(bus.rdata1), 64'(exp1_q.pop_front()));
        end
        if (bus.bram_map_wr) begin
            if (wexp_q.size() == 0) note_fail("bram_wr_unexpected");
            else check("bram_wr_beat", {29'b0, bus.bram_map_addr, bus.bram_map_dwrite},
                       wexp_q.pop_front());
        end
    end

    // ---------------- drivers (called aligned to 1 time unit after a rising edge)
    task automatic port0_access(input logic wr, input logic [18:0] a, input logic [15:0] d,
                                input logic lk, input logic scramble, output int lat);
        logic [15:0] e;
        if (wr) begin
            ref_mem[a] = d;
            wexp_q.push_back({29'b0, a, d});
            e = last_rd0;
        end else begin
            e = ref_word(a);
            last_rd0 = e;
        end
        exp0_q.push_back(e);
        bus.req0 = 1'b1; bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = lk;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (scramble && lat == 2) begin
                bus.wr0 = ~wr; bus.addr0 = ~a; bus.wdata0 = ~d;
            end
        end while (!bus.ack0 && lat < BUDGET);
        if (!bus.ack0) note_fail("ack0_timeout");
        @(posedge clk); #1;
        bus.req0 = 1'b0;
    endtask

    task automatic port1_access(input logic [18:0] a, output int lat);
        exp1_q.push_back(ref_word(a));
        bus.req1 = 1'b1; bus.addr1 = a;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.ack1 && lat < BUDGET);
        if (!bus.ack1) note_fail("ack1_timeout");
        @(posedge clk); #1;
        bus.req1 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_state"},  64'(dbg_state),           64'd0);
        check({p, "_ack0"},   64'(bus.ack0),            64'd0);
        check({p, "_ack1"},   64'(bus.ack1),            64'd0);
        check({p, "_wr"},     64'(bus.bram_map_wr),     64'd0);
        check({p, "_busy"},   64'(bus.busy),            64'd0);
        check({p, "_addr"},   64'(bus.bram_map_addr),   64'd0);
        check({p, "_dwrite"}, 64'(bus.bram_map_dwrite), 64'd0);
        check({p, "_rdata0"}, 64'(bus.rdata0),          64'd0);
        check({p, "_rdata1"}, 64'(bus.rdata1),          64'd0);
    endtask

    task automatic check_order(input string p, input int exp[$]);
        check({p, "_count"}, 64'(ack_log.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < ack_log.size(); i++)
            check({p, "_port"}, 64'(ack_log[i]), 64'(exp[i]));
    endtask

    initial begin
        #500000;
        note_fail("watchdog");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence
    initial begin
        int lat_a, lat_b, lat_c, lat_d;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0; bus.lock0 = 1'b0;
        bus.req1 = 1'b0; bus.addr1 = '0;
        last_rd0 = '0;
        ref_mem[19'h00105]  = 16'h0007;
        bram_mem[19'h00105] = 16'h0007;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Persistent tie from reset: port 0 first, then strict alternation.
        ack_log.delete();
        fork
            begin
                port0_access(1'b0, 19'h40010, 16'h0, 1'b0, 1'b0, lat_a);
                port0_access(1'b0, 19'h40011, 16'h0, 1'b0, 1'b0, lat_b);
            end
            begin
                port1_access(19'h00200, lat_c);
                port1_access(19'h00201, lat_d);
            end
        join
        check("tie_first_latency", 64'(lat_a), 64'd4);
        check_order("tie_order", '{0, 1, 0, 1});

        // Single read by port 1: ISSUE on the second sampled negedge, ack on the fourth.
        ack_log.delete();
        fork
            port1_access(19'h00105, lat_a);
            begin
                repeat (2) @(negedge clk);
                check("read_issue_state", 64'(dbg_state), 64'd1);
                check("read_issue_addr", 64'(bus.bram_map_addr), 64'h00105);
            end
        join
        check("read_latency", 64'(lat_a), 64'd4);
        check("read_rdata1", 64'(bus.rdata1), 64'h0007);

        // Locked read-modify-write while port 1 keeps requesting.
        ack_log.delete();
        fork
            begin
                port0_access(1'b0, 19'h40020, 16'h0, 1'b1, 1'b0, lat_a);
                port0_access(1'b1, 19'h40020, 16'h1234, 1'b0, 1'b0, lat_b);
            end
            port1_access(19'h00300, lat_c);
        join
        check("rmw_read_latency", 64'(lat_a), 64'd4);
        check_order("rmw_order", '{0, 0, 1});
        check("rmw_busy_after", 64'(bus.busy), 64'd0);

        // Single write; port 0 fields are scrambled after issue and must be ignored.
        ack_log.delete();
        port0_access(1'b1, 19'h000A3, 16'h0002, 1'b0, 1'b1, lat_a);
        check("write_latency", 64'(lat_a), 64'd3);
        check("write_rdata0_kept", 64'(bus.rdata0), 64'(init_word(19'h40020)));

        // Reset while a port 1 read sits in WAIT.
        bus.req1 = 1'b1; bus.addr1 = 19'h00222;
        repeat (3) @(negedge clk);
        check("abort_read_in_wait", 64'(dbg_state), 64'd2);
        rst = 1'b1; bus.req1 = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort_read");
        last_rd0 = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_read_quiet", 64'(dbg_state), 64'd0);
        @(posedge clk); #1;

        // Reset while a write is in ISSUE: the write strobe drops on that edge.
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 19'h400AA; bus.wdata0 = 16'hBEEF;
        bus.lock0 = 1'b0;
        wexp_q.push_back({29'b0, 19'h400AA, 16'hBEEF});
        ref_mem[19'h400AA] = 16'hBEEF;
        repeat (2) @(negedge clk);
        check("abort_write_issue", 64'(dbg_state), 64'd1);
        check("abort_write_wr_high", 64'(bus.bram_map_wr), 64'd1);
        rst = 1'b1; bus.req0 = 1'b0; bus.wr0 = 1'b0;
        @(negedge clk);
        check("abort_write_wr_low", 64'(bus.bram_map_wr), 64'd0);
        check("abort_write_state", 64'(dbg_state), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back port 1 reads with req1 held across the boundary.
        ack_log.delete();
        port1_access(19'h00150, lat_a);
        port1_access(19'h00151, lat_b);
        check("b2b_latency", 64'(lat_b), 64'd4);
        check_order("b2b_order", '{1, 1});

        // Random traffic: port 0 in its own address window, port 1 below it.
        fork
            begin : rand_p0
                logic [18:0] a0;
                logic        w0, l0;
                int          g0, t0;
                for (int i = 0; i < 30; i++) begin
                    g0 = $urandom_range(0, 3);
                    repeat (g0) begin @(posedge clk); #1; end
                    a0 = 19'h40000 | 19'($urandom_range(0, 15));
                    w0 = 1'($urandom_range(0, 1));
                    l0 = (i < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
                    port0_access(w0, a0, 16'($urandom), l0, 1'b0, t0);
                end
            end
            begin : rand_p1
                logic [18:0] a1;
                int          g1, t1;
                for (int j = 0; j < 30; j++) begin
                    g1 = $urandom_range(0, 3);
                    repeat (g1) begin @(posedge clk); #1; end
                    a1 = 19'($urandom_range(0, 32'h3FFFF));
                    port1_access(a1, t1);
                end
            end
        join

        repeat (5) @(negedge clk);
        check("final_exp0_empty", 64'(exp0_q.size()), 64'd0);
        check("final_exp1_empty", 64'(exp1_q.size()), 64'd0);
        check("final_wexp_empty", 64'(wexp_q.size()), 64'd0);
        check("final_busy", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
